// File: rtl/memory_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : memory_stage
// Description : Pipeline MEM stage. Resolves CBZ branches, runs loads/stores
//               over a req/ack data-memory handshake, stalls while an access
//               is outstanding and registers results into MEM/WB.
//               Optional macro MEM_ALIGN_CHECK_EN enables misalignment faults.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_M,
  input  logic [N-1:0] aluResult_M,
  input  logic [N-1:0] writeData_M,
  input  logic [N-1:0] PCBranch_M,
  input  logic         zero_M,
  input  logic         Branch_M,
  input  logic         memRead_M,
  input  logic         memWrite_M,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_ack,
  input  logic [N-1:0] dm_rdata,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_out,
  output logic         stall_M,
  output logic         valid_W,
  output logic [N-1:0] aluResult_W,
  output logic [N-1:0] readData_W,
  output logic         misalign_W
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WAIT = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  logic [1:0]   r_state;
  logic         r_dm_we;
  logic [N-1:0] r_dm_addr;
  logic [N-1:0] r_dm_wdata;
  logic [N-1:0] r_rdata_q;
  logic         r_valid_w;
  logic [N-1:0] r_alu_result_w;
  logic [N-1:0] r_read_data_w;
  logic         r_misalign_w;

  logic         w_memop;
  logic         w_misalign;
  logic         w_issue;
  logic         w_stall;
  logic         w_is_load;

  assign w_memop   = valid_M & (memRead_M | memWrite_M);
  // A simultaneous read+write request is handled as a store.
  assign w_is_load = memRead_M & ~memWrite_M;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_memop & (aluResult_M[2:0] != 3'b000);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue = (r_state == c_ST_IDLE) & w_memop & ~w_misalign;
  // Nothing may hold the pipeline while reset is asserted.
  assign w_stall = ~reset & (w_issue | (r_state == c_ST_WAIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_ST_IDLE;
      r_dm_we    <= 1'b0;
      r_dm_addr  <= '0;
      r_dm_wdata <= '0;
      r_rdata_q  <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_issue) begin
            r_state    <= c_ST_WAIT;
            r_dm_addr  <= aluResult_M;
            r_dm_wdata <= writeData_M;
            r_dm_we    <= memWrite_M;
          end
        end
        c_ST_WAIT: begin
          if (dm_ack) begin
            r_rdata_q <= dm_rdata;
            r_state   <= c_ST_DONE;
          end
        end
        c_ST_DONE: r_state <= c_ST_IDLE;
        default:   r_state <= c_ST_IDLE;
      endcase
    end
  end

  // MEM/WB boundary: a stalled cycle inserts a bubble and holds data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid_w      <= 1'b0;
      r_alu_result_w <= '0;
      r_read_data_w  <= '0;
      r_misalign_w   <= 1'b0;
    end else if (w_stall) begin
      r_valid_w <= 1'b0;
    end else begin
      r_valid_w      <= valid_M;
      r_alu_result_w <= aluResult_M;
      r_read_data_w  <= ((r_state == c_ST_DONE) & w_is_load) ? r_rdata_q : '0;
      r_misalign_w   <= w_misalign;
    end
  end

  assign dm_req       = (r_state == c_ST_WAIT);
  assign dm_we        = r_dm_we;
  assign dm_addr      = r_dm_addr;
  assign dm_wdata     = r_dm_wdata;
  assign stall_M      = w_stall;
  assign PCSrc_M      = valid_M & Branch_M & zero_M;
  assign PCBranch_out = PCBranch_M;
  assign valid_W      = r_valid_w;
  assign aluResult_W  = r_alu_result_w;
  assign readData_W   = r_read_data_w;
  assign misalign_W   = r_misalign_w;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_memory_stage
// Description : Self-checking bench for memory_stage: vector table, directed
//               multi-cycle sequences and a randomized instruction stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_stage;

  localparam int N = 64;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         valid_M;
  logic [N-1:0] aluResult_M;
  logic [N-1:0] writeData_M;
  logic [N-1:0] PCBranch_M;
  logic         zero_M;
  logic         Branch_M;
  logic         memRead_M;
  logic         memWrite_M;
  logic         dm_req;
  logic         dm_we;
  logic [N-1:0] dm_addr;
  logic [N-1:0] dm_wdata;
  logic         dm_ack;
  logic [N-1:0] dm_rdata;
  logic         PCSrc_M;
  logic [N-1:0] PCBranch_out;
  logic         stall_M;
  logic         valid_W;
  logic [N-1:0] aluResult_W;
  logic [N-1:0] readData_W;
  logic         misalign_W;

  memory_stage #(.N(N)) dut (
    .clk(clk), .reset(reset), .valid_M(valid_M), .aluResult_M(aluResult_M),
    .writeData_M(writeData_M), .PCBranch_M(PCBranch_M), .zero_M(zero_M),
    .Branch_M(Branch_M), .memRead_M(memRead_M), .memWrite_M(memWrite_M),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .PCSrc_M(PCSrc_M),
    .PCBranch_out(PCBranch_out), .stall_M(stall_M), .valid_W(valid_W),
    .aluResult_W(aluResult_W), .readData_W(readData_W), .misalign_W(misalign_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Device-side memory (what the memory actually holds) and the model's view.
  logic [63:0] dmem    [logic [63:0]];
  logic [63:0] ref_mem [logic [63:0]];

  typedef struct {
    logic        v, rd, wr, br, zr;
    logic [63:0] alu, pcb;
    logic        exp_pcsrc, exp_valid_w;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] fill_data(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
  endfunction

  // Runs one instruction through MEM, acting as the memory (ack after
  // 'delay' extra request cycles) and checking against the spec's rules.
  task automatic do_instr(input logic v, input logic rd, input logic wr,
                          input logic br, input logic zr,
                          input logic [63:0] addr, input logic [63:0] wd,
                          input logic [63:0] pcb, input int delay);
    logic        memop, issue, st, adv;
    logic [63:0] exp_rd;
    int          stalls, reqs, cyc;
    memop  = v & (rd | wr);
    issue  = memop & !(ALIGN_EN && (addr[2:0] != 3'b000));
    exp_rd = '0;
    if (issue && rd && !wr)
      exp_rd = ref_mem.exists(addr) ? ref_mem[addr] : fill_data(addr);
    if (issue && wr) ref_mem[addr] = wd;

    valid_M = v; memRead_M = rd; memWrite_M = wr; Branch_M = br; zero_M = zr;
    aluResult_M = addr; writeData_M = wd; PCBranch_M = pcb;
    #1;
    check("pcsrc", {63'd0, PCSrc_M}, {63'd0, v & br & zr});
    check("pcbranch_out", PCBranch_out, pcb);

    stalls = 0; reqs = 0; cyc = 0; adv = 1'b0;
    while (!adv && cyc < 20) begin
      st = stall_M;
      if (st) stalls++;
      if (dm_req) begin
        reqs++;
        check("dm_addr", dm_addr, addr);
        check("dm_we", {63'd0, dm_we}, {63'd0, wr});
        check("dm_wdata", dm_wdata, wd);
        if (reqs == delay + 1) begin
          dm_ack = 1'b1;
          if (dm_we) dmem[dm_addr] = dm_wdata;
          else dm_rdata = dmem.exists(dm_addr) ? dmem[dm_addr] : fill_data(dm_addr);
        end
      end
      @(posedge clk); #1;
      dm_ack   = 1'b0;
      dm_rdata = {$urandom, $urandom};
      cyc++;
      if (!st) adv = 1'b1;
      else check("bubble_valid_w", {63'd0, valid_W}, 64'd0);
    end
    check("advance_timeout", {63'd0, adv}, 64'd1);
    check("valid_w", {63'd0, valid_W}, {63'd0, v});
    check("alu_result_w", aluResult_W, addr);
    check("read_data_w", readData_W, exp_rd);
    check("stall_cycles", 64'(stalls), issue ? 64'(2 + delay) : 64'd0);
    check("req_cycles", 64'(reqs), issue ? 64'(1 + delay) : 64'd0);
    check("misalign_w", {63'd0, misalign_W}, {63'd0, memop & ~issue});
  endtask

  initial begin
    reset = 1'b1; valid_M = 0; aluResult_M = '0; writeData_M = '0; PCBranch_M = '0;
    zero_M = 0; Branch_M = 0; memRead_M = 0; memWrite_M = 0; dm_ack = 0; dm_rdata = '0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h10, 64'h0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h20, 64'h40, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h20, 64'h40, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h30, 64'h80, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h300, 64'h0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1234, 1'b0, 1'b1};

    @(posedge clk); @(posedge clk); #1;
    check("rst_dm_req", {63'd0, dm_req}, 64'd0);
    check("rst_dm_we", {63'd0, dm_we}, 64'd0);
    check("rst_dm_addr", dm_addr, 64'd0);
    check("rst_dm_wdata", dm_wdata, 64'd0);
    check("rst_valid_w", {63'd0, valid_W}, 64'd0);
    check("rst_alu_result_w", aluResult_W, 64'd0);
    check("rst_read_data_w", readData_W, 64'd0);
    check("rst_misalign_w", {63'd0, misalign_W}, 64'd0);
    check("rst_stall", {63'd0, stall_M}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      valid_M = vecs[i].v; memRead_M = vecs[i].rd; memWrite_M = vecs[i].wr;
      Branch_M = vecs[i].br; zero_M = vecs[i].zr;
      aluResult_M = vecs[i].alu; PCBranch_M = vecs[i].pcb;
      #1;
      check("vec_pcsrc", {63'd0, PCSrc_M}, {63'd0, vecs[i].exp_pcsrc});
      check("vec_pcbranch_out", PCBranch_out, vecs[i].pcb);
      check("vec_stall", {63'd0, stall_M}, 64'd0);
      @(posedge clk); #1;
      check("vec_valid_w", {63'd0, valid_W}, {63'd0, vecs[i].exp_valid_w});
      check("vec_alu_result_w", aluResult_W, vecs[i].alu);
      check("vec_read_data_w", readData_W, 64'd0);
    end

    // Load with one extra wait cycle, then a same-cycle-ack store.
    dmem[64'h100] = 64'hDEAD; ref_mem[64'h100] = 64'hDEAD;
    do_instr(1, 1, 0, 0, 0, 64'h100, 64'h0, 64'h0, 1);
    do_instr(1, 0, 1, 0, 0, 64'h08, 64'h55, 64'h0, 0);
    do_instr(1, 1, 0, 0, 0, 64'h08, 64'h0, 64'h0, 0);

    // Reset while a request is outstanding.
    valid_M = 1; memRead_M = 1; memWrite_M = 0; Branch_M = 0; aluResult_M = 64'h200;
    #1;
    check("pre_issue_stall", {63'd0, stall_M}, 64'd1);
    @(posedge clk); #1;
    check("wait_dm_req", {63'd0, dm_req}, 64'd1);
    reset = 1'b1;
    #1;
    check("abort_dm_req", {63'd0, dm_req}, 64'd0);
    check("abort_stall", {63'd0, stall_M}, 64'd0);
    check("abort_valid_w", {63'd0, valid_W}, 64'd0);
    valid_M = 0; memRead_M = 0;
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;
    do_instr(1, 1, 0, 0, 0, 64'h200, 64'h0, 64'h0, 2);

    // Misaligned address: faults with the check enabled, issued as-is otherwise.
    do_instr(1, 1, 0, 0, 0, 64'h103, 64'h0, 64'h0, 0);
    do_instr(1, 1, 0, 0, 0, 64'h108, 64'h0, 64'h0, 1);

    for (int k = 0; k < 60; k++) begin
      int          kind;
      logic [63:0] a;
      kind = int'($urandom_range(0, 9));
      a    = 64'h1000 | (64'($urandom_range(0, 15)) << 3);
      if (kind < 4)
        do_instr(1, 1, 0, 0, 0, a, {$urandom, $urandom}, 64'h0, int'($urandom_range(0, 3)));
      else if (kind < 7)
        do_instr(1, 0, 1, 0, 0, a, {$urandom, $urandom}, 64'h0, int'($urandom_range(0, 3)));
      else
        do_instr(1'($urandom_range(0, 1)), 0, 0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), {$urandom, $urandom}, 64'h0,
                 {$urandom, $urandom}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
